// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding, register
// address widths and the saturating counter helper.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MC_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  typedef enum logic [1:0] {
    StRun    = ST_RUN,
    StMcWait = ST_MC_WAIT,
    StFlush  = ST_FLUSH
  } stall_state_e;

  localparam int unsigned CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard comparator: flags an ID instruction that reads the register a load in EX
// is about to write. x0 is never a hazard.
module hazard_cmp
  import riscv_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  load_use_o
);

  always_comb begin
    load_use_o = ex_mem_read_i && (ex_rd_i != REG_X0) &&
                 ((ex_rd_i == id_rs1_i) || (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: prioritises branch flushes, multi-cycle EX waits and
// load-use stalls into PC / IF-ID / ID-EX strobes. STALL_PERF_CNT_EN adds perf counters.
module pipeline_stall_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYC  = 1,
  parameter int unsigned MC_MAX_CYC = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mc_start,
  input  logic                  mc_done,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_hold,
  output logic                  mc_timeout,
  output logic [1:0]            state_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles
`endif
);

  localparam logic [CNT_W-1:0] FlushLoad = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] McLast    = CNT_W'(MC_MAX_CYC - 1);

  stall_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             load_use;

  hazard_cmp u_hazard_cmp (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs2_i  (id_use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = StFlush;
          cnt_d        = FlushLoad;
        end else if (mc_start) begin
          state_d = StMcWait;
          cnt_d   = '0;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      StMcWait: begin
        // A completing op releases the pipeline in the same cycle.
        if (mc_done) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_hold     = 1'b1;
          if (cnt_q >= McLast) begin
            timeout_d = 1'b1;
            state_d   = StRun;
            cnt_d     = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      StFlush: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (ex_branch_taken) begin
          cnt_d = FlushLoad;
        end else if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mc_timeout = timeout_q;
  assign state_o    = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (FLUSH_CYC=2, MC_MAX_CYC=34) with a cycle-level
// reference model compared on every falling edge plus hand-computed literal checks.
module tb_pipeline_stall_ctrl;

  localparam int FlushCyc = 2;
  localparam int McMax    = 34;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs2, ex_mem_read, ex_branch_taken, mc_start, mc_done;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mc_timeout;
  logic [1:0] state_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_stall_ctrl #(
    .FLUSH_CYC  (FlushCyc),
    .MC_MAX_CYC (McMax)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mc_start        (mc_start),
    .mc_done         (mc_done),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_hold         (ex_hold),
    .mc_timeout      (mc_timeout),
    .state_o         (state_o)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: remaining flush cycles, cycles spent waiting on the multi-cycle unit.
  int          m_flush_rem;
  int          m_mc_age;
  logic        m_to;
  longint      m_stall_n, m_flush_n;
  logic        e_pc, e_ifw, e_fl, e_bub, e_hold;
  logic [1:0]  e_state;
  logic        m_lu;

  always_comb begin
    m_lu    = ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
    e_pc    = 1'b1;
    e_ifw   = 1'b1;
    e_fl    = 1'b0;
    e_bub   = 1'b0;
    e_hold  = 1'b0;
    e_state = (m_mc_age >= 0) ? 2'd1 : (m_flush_rem > 0) ? 2'd2 : 2'd0;
    if (m_mc_age >= 0) begin
      if (!mc_done) begin
        e_pc   = 1'b0;
        e_ifw  = 1'b0;
        e_hold = 1'b1;
      end
    end else if (m_flush_rem > 0 || ex_branch_taken) begin
      e_fl  = 1'b1;
      e_bub = 1'b1;
    end else if (!mc_start && m_lu) begin
      e_pc  = 1'b0;
      e_ifw = 1'b0;
      e_bub = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flush_rem <= 0;
      m_mc_age    <= -1;
      m_to        <= 1'b0;
      m_stall_n   <= 0;
      m_flush_n   <= 0;
    end else begin
      if (!e_pc && m_stall_n < 64'hFFFF_FFFF) m_stall_n <= m_stall_n + 1;
      if (e_fl && m_flush_n < 64'hFFFF_FFFF) m_flush_n <= m_flush_n + 1;
      if (m_mc_age >= 0) begin
        if (mc_done) m_mc_age <= -1;
        else if (m_mc_age + 1 >= McMax) begin
          m_to     <= 1'b1;
          m_mc_age <= -1;
        end else m_mc_age <= m_mc_age + 1;
      end else if (m_flush_rem > 0) begin
        m_flush_rem <= ex_branch_taken ? FlushCyc : m_flush_rem - 1;
      end else if (ex_branch_taken) begin
        m_flush_rem <= FlushCyc;
      end else if (mc_start) begin
        m_mc_age <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_pc_write", {31'd0, pc_write}, {31'd0, e_pc});
    chk("m_if_id_write", {31'd0, if_id_write}, {31'd0, e_ifw});
    chk("m_if_id_flush", {31'd0, if_id_flush}, {31'd0, e_fl});
    chk("m_id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e_bub});
    chk("m_ex_hold", {31'd0, ex_hold}, {31'd0, e_hold});
    chk("m_mc_timeout", {31'd0, mc_timeout}, {31'd0, m_to});
    chk("m_state", {30'd0, state_o}, {30'd0, e_state});
`ifdef STALL_PERF_CNT_EN
    chk("m_stall_cycles", stall_cycles, m_stall_n[31:0]);
    chk("m_flush_cycles", flush_cycles, m_flush_n[31:0]);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int holds, fl, st;
    logic seen;
    clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("rst_if_id_write", {31'd0, if_id_write}, 32'd1);
    chk("rst_flush", {31'd0, if_id_flush}, 32'd0);
    chk("rst_bubble", {31'd0, id_ex_bubble}, 32'd0);
    chk("rst_hold", {31'd0, ex_hold}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_timeout", {31'd0, mc_timeout}, 32'd0);
    step(); rst_n = 1'b1;

    // Load-use on rs1, then x0 never a hazard
    step(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; #2;
    chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
    chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    step(); clear(); #2;
    chk("lu_one_cycle", {31'd0, pc_write}, 32'd1);
    step(); ex_mem_read = 1'b1; #2;
    chk("lu_x0_pc", {31'd0, pc_write}, 32'd1);
    chk("lu_x0_bubble", {31'd0, id_ex_bubble}, 32'd0);

    // rs2 gating
    step(); clear(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; #2;
    chk("rs2_unused_pc", {31'd0, pc_write}, 32'd1);
    step(); id_use_rs2 = 1'b1; #2;
    chk("rs2_used_pc", {31'd0, pc_write}, 32'd0);
    step(); clear();

    // Multi-cycle op: five held cycles, released with mc_done
    step(); mc_start = 1'b1; #2;
    chk("mc_start_hold", {31'd0, ex_hold}, 32'd0);
    holds = 0;
    for (int i = 0; i < 5; i++) begin
      step(); clear(); #2; holds += int'(ex_hold);
    end
    chk("mc_hold_cycles", holds, 32'd5);
    step(); mc_done = 1'b1; #2;
    chk("mc_done_hold", {31'd0, ex_hold}, 32'd0);
    chk("mc_done_pc", {31'd0, pc_write}, 32'd1);
    step(); clear(); #2;
    chk("mc_done_state", {30'd0, state_o}, 32'd0);

    // Branch during MC_WAIT is ignored
    step(); mc_start = 1'b1;
    step(); clear(); ex_branch_taken = 1'b1; #2;
    chk("mc_br_hold", {31'd0, ex_hold}, 32'd1);
    chk("mc_br_flush", {31'd0, if_id_flush}, 32'd0);
    step(); clear(); mc_done = 1'b1;
    step(); clear(); #2;
    chk("mc_br_state", {30'd0, state_o}, 32'd0);

    // Timeout: 34 held cycles then sticky mc_timeout
    step(); mc_start = 1'b1;
    holds = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(); clear(); #2;
      if (mc_timeout) seen = 1'b1;
      else holds += int'(ex_hold);
    end
    chk("to_seen", {31'd0, seen}, 32'd1);
    chk("to_hold_cycles", holds, 32'd34);
    chk("to_state", {30'd0, state_o}, 32'd0);

    // Branch with load-use: 1 + FLUSH_CYC flush cycles, no stall while flushing
    step(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; ex_branch_taken = 1'b1; #2;
    chk("br_flush", {31'd0, if_id_flush}, 32'd1);
    chk("br_bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("br_pc_write", {31'd0, pc_write}, 32'd1);
    fl = 1; st = 0;
    for (int i = 0; i < 2; i++) begin
      step(); ex_branch_taken = 1'b0; #2;
      fl += int'(if_id_flush); st += int'(!pc_write);
    end
    chk("br_flush_cycles", fl, 32'd3);
    chk("br_stall_cycles", st, 32'd0);
    step(); #2;
    chk("br_after_stall", {31'd0, pc_write}, 32'd0);

    // Branch re-presented in FLUSH reloads the count
    step(); clear(); ex_branch_taken = 1'b1; #2; fl = int'(if_id_flush);
    step(); #2; fl += int'(if_id_flush);
    for (int i = 0; i < 4; i++) begin
      step(); clear(); #2; fl += int'(if_id_flush);
    end
    chk("reload_flush_cycles", fl, 32'd4);

    // Async reset in MC_WAIT cycle 3 clears state and sticky timeout
    step(); mc_start = 1'b1;
    step(); clear();
    step();
    step(); #2; rst_n = 1'b0; #1;
    chk("arst_mc_state", {30'd0, state_o}, 32'd0);
    chk("arst_mc_timeout", {31'd0, mc_timeout}, 32'd0);
    chk("arst_mc_hold", {31'd0, ex_hold}, 32'd0);
    chk("arst_mc_pc", {31'd0, pc_write}, 32'd1);
    step(); rst_n = 1'b1;

    // Async reset in FLUSH
    step(); ex_branch_taken = 1'b1;
    step(); clear(); #1; rst_n = 1'b0; #1;
    chk("arst_fl_state", {30'd0, state_o}, 32'd0);
    chk("arst_fl_flush", {31'd0, if_id_flush}, 32'd0);
    step(); rst_n = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
